// File: rtl/uart_tx_if.sv
// Write-side bus of the UART transmitter: byte push handshake plus FIFO/line status.
interface uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;

    modport master (output wr_en, output wr_data, input full, input empty, input busy);
    modport slave  (input wr_en, input wr_data, output full, output empty, output busy);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO, LSB-first serialisation at a fixed baud rate.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      uart_txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, empty_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic push, pop, atBoundary;

    // full is the registered flag, so a push while full is dropped without touching any state
    assign push       = bus.wr_en && !full_q;
    assign pop        = (state_q == IDLE) && !empty_q;
    assign atBoundary = (baudCnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        baudCnt_d = (state_q == IDLE || atBoundary) ? '0 : baudCnt_q + CNT_W'(1);
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    shift_d = mem_q[rdPtr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem_q[rdPtr_q];
`endif
                    state_d = START;
                end
            end
            START: begin
                if (atBoundary) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (atBoundary) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (atBoundary) state_d = STOP;
            end
`endif
            STOP: begin
                if (atBoundary) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The line level is chosen from the state being entered so txd comes straight off a flop
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q   <= count_d;
            full_q    <= (count_d == DEPTH_C);
            empty_q   <= (count_d == '0);
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.busy  = (state_q != IDLE);
    assign uart_txd  = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed bench for uart_tx; a queue/timer model predicts flags and frames,
// and a mid-bit sampling line monitor decodes what actually appears on uart_txd.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    uart_tx_if bus();

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .uart_txd (txd)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: pending bytes, frame-in-progress timer, and the frames it expects to see
    logic [7:0] mQ[$];
    frame_t     expQ[$];
    int         mTimer = 0;
    int         cyc = 0;

    initial forever begin
        bit popNow, pushNow;
        frame_t f;
        @(posedge clk);
        cyc++;
        if (rst !== 1'b0) begin
            mQ.delete();
            expQ.delete();
            mTimer = 0;
        end else begin
            popNow  = (mTimer == 0) && (mQ.size() > 0);
            pushNow = (bus.wr_en === 1'b1) && (mQ.size() < DEPTH);
            if (mTimer > 0) mTimer--;
            if (popNow) begin
                f.data = mQ.pop_front();
                f.cyc  = cyc;
                expQ.push_back(f);
                mTimer = FRAME_CLKS;
            end
            if (pushNow) mQ.push_back(bus.wr_data);
        end
    end

    // Flag and idle-line checks against the model every cycle outside reset
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            checkOutput("empty", bus.empty, mQ.size() == 0);
            checkOutput("full",  bus.full,  mQ.size() == DEPTH);
            checkOutput("busy",  bus.busy,  mTimer > 0);
            if (mTimer == 0) checkOutput("txdIdle", txd, 1);
        end
    end

    // Line monitor: detect start bit, sample each bit in its middle, compare with the model's frame
    int          framesSeen = 0;
    bit          monBusy = 0;
    bit          monAbort;
    int          monStart;
    logic [10:0] monBits;

    initial forever begin
        frame_t e;
        @(negedge clk);
        if (rst === 1'b0 && txd === 1'b0) begin
            monBusy  = 1;
            monAbort = 0;
            monStart = cyc;
            monBits  = '1;
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int w = 0; w < ((b == 0) ? CPB / 2 : CPB); w++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) monAbort = 1;
                end
                if (monAbort) break;
                monBits[b] = txd;
            end
            if (!monAbort) begin
                framesSeen++;
                checkOutput("frameExpected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("startCycle", monStart, e.cyc);
                    checkOutput("startBit", monBits[0], 0);
                    checkOutput("dataByte", monBits[8:1], e.data);
`ifdef UART_TX_PARITY_EN
                    checkOutput("parityBit", monBits[9], ^e.data);
`endif
                    checkOutput("stopBit", monBits[FRAME_BITS-1], 1);
                end
            end
            monBusy = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle write; back-to-back calls produce writes on consecutive clocks
    task automatic applyStimulus(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (!(mTimer == 0 && mQ.size() == 0 && expQ.size() == 0 && !monBusy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, n < budget, 1);
    endtask

    initial begin
        int base, s, n;
        logic [7:0] burst [5];
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h3C; burst[4] = 8'h81;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;

        // Reset behaviour and a quiet line afterwards
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstTxd", txd, 1);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstEmpty", bus.empty, 1);
        checkOutput("rstFull", bus.full, 0);
        rst = 1'b0;
        idleCycles(200);
        checkOutput("quietFrames", framesSeen, 0);

        // Single byte, including exact busy drop after the frame
        applyStimulus(8'hA5);
        s = cyc + 1;
        while (cyc < s + FRAME_CLKS - 1) idleCycles(1);
        checkOutput("busyLastClk", bus.busy, 1);
        idleCycles(1);
        checkOutput("busyDropped", bus.busy, 0);
        waitDrain("drainSingle", 500);
        checkOutput("singleFrames", framesSeen, 1);

        // Consecutive-clock burst of five: first byte pops at once, so none is lost
        base = framesSeen;
        for (int i = 0; i < 5; i++) applyStimulus(burst[i]);
        waitDrain("drainBurst", 2000);
        checkOutput("burstFrames", framesSeen - base, 5);

        // Fill the FIFO during a frame; the fifth write is dropped
        base = framesSeen;
        applyStimulus(8'h11);
        idleCycles(3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h20 + 8'(i));
            if (i == 3) checkOutput("fullAfter4", bus.full, 1);
        end
        checkOutput("fullAfterDrop", bus.full, 1);
        waitDrain("drainFull", 2000);
        checkOutput("fullFrames", framesSeen - base, 5);

        // Push coinciding with the pop edge keeps count at one
        base = framesSeen;
        applyStimulus(8'hC3);
        applyStimulus(8'h5A);
        n = 0;
        while (mTimer != 0 && n < 500) begin idleCycles(1); n++; end
        checkOutput("waitPopEdge", n < 500, 1);
        applyStimulus(8'h96);
        checkOutput("simulEmpty", bus.empty, 0);
        checkOutput("simulFull", bus.full, 0);
        waitDrain("drainSimul", 1000);
        checkOutput("simulFrames", framesSeen - base, 3);

        // Randomised traffic, including writes that hit a full FIFO
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom));
            else idleCycles(1);
        end
        waitDrain("drainRandom", 5000);

`ifdef UART_TX_PARITY_EN
        // Parity frames: odd-weight and even-weight bytes back to back
        base = framesSeen;
        applyStimulus(8'h07);
        applyStimulus(8'h03);
        waitDrain("drainParity", 1000);
        checkOutput("parityFrames", framesSeen - base, 2);
`endif

        // Reset in data bit 3 of 0xF0 with two bytes queued: frame aborted, queue discarded
        base = framesSeen;
        applyStimulus(8'hF0);
        s = cyc + 1;
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        while (cyc < s + 4 * CPB + 4) idleCycles(1);
        rst = 1'b1;
        #1;
        checkOutput("rstMidTxd", txd, 1);
        checkOutput("rstMidBusy", bus.busy, 0);
        idleCycles(3);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("rstMidEmpty", bus.empty, 1);
        idleCycles(300);
        checkOutput("rstMidFrames", framesSeen - base, 0);
        checkOutput("rstMidTxdIdle", txd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
